exu_fpu_seq_ctl: RTL
====================

EXU_FPU_SEQ_CTL -- requirements
Module: exu_fpu_seq_ctl

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, meaning request FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port req_valid / req_ready  in / out  1 / 1  request handshake from the decode side.
REQ-005 SHALL have port req_op / req_rm / req_tag  in  4 / 3 / 5  FPU operation code, instruction rounding mode, destination tag.
REQ-006 SHALL have port flush  in  1  kill all queued and in-flight work.
REQ-007 SHALL have port fpu_in_valid / fpu_in_ready  out / in  1 / 1  issue handshake to the FPU.
REQ-008 SHALL have port fpu_op / fpu_rnd_mode  out  4 / 3  head-entry operation and resolved rounding mode.
REQ-009 SHALL have port fpu_out_valid / fpu_status  in  1 / 5  FPU completion pulse and exception flags (NV,DZ,OF,UF,NX).
REQ-010 SHALL have port frm_wr_en / frm_wr_data / fflags_clr  in  1 / 3 / 1  CSR writes to frm; clear of fflags.
REQ-011 SHALL have port frm / fflags  out  3 / 5  current dynamic rounding mode; sticky exception flags.
REQ-012 SHALL have port done_valid / done_tag / done_illegal  out  1 / 5 / 1  completion pulse, its tag, illegal-rounding-mode indication.
REQ-013 SHALL have port busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-014 SHALL assert req_ready exactly when FIFO holds fewer than QDEPTH entries; no same-cycle bypass when full.
REQ-015 SHALL resolve rounding mode at enqueue: req_rm==7 -> current frm (frm_wr_en in the same cycle does not apply); else req_rm.
REQ-016 SHALL mark an entry illegal when its resolved mode is 5, 6 or 7.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN.
REQ-018 IDLE: head legal -> ISSUE; head illegal -> pop it, stay IDLE, next cycle done_valid=1, done_illegal=1, done_tag=entry tag.
REQ-019 ISSUE: fpu_in_valid=1, fpu_op/fpu_rnd_mode from head, both stable until fpu_in_ready; on fpu_in_ready pop head -> WAIT.
REQ-020 WAIT: on fpu_out_valid -> IDLE; next cycle done_valid=1, done_illegal=0, done_tag=issued tag, fflags |= fpu_status.
REQ-021 fpu_in_valid SHALL be 0 in every state except ISSUE.
REQ-022 Minimum latency: accept edge 0 -> fpu_in_valid at cycle 2; fpu_out_valid at cycle k -> done_valid at cycle k+1.
REQ-023 done_valid SHALL be a single-cycle pulse per completed or illegal entry, in FIFO order.
REQ-024 Flush SHALL empty the FIFO that cycle; any req accepted in the flush cycle is dropped.
REQ-025 Flush in ISSUE without fpu_in_ready -> IDLE; flush with fpu_in_ready, or in WAIT without fpu_out_valid -> DRAIN.
REQ-026 Flush in WAIT coinciding with fpu_out_valid -> IDLE; that result is discarded.
REQ-027 DRAIN: wait for fpu_out_valid -> IDLE; no done_valid, no fflags update; FIFO may accept new requests, issue starts after IDLE.
REQ-028 A pending done_valid/fflags update scheduled before flush (REQ-018/020) SHALL still occur.
REQ-029 frm SHALL load frm_wr_data on frm_wr_en; queued entries keep their resolved mode.
REQ-030 fflags_clr with a same-cycle accumulate SHALL yield fflags = fpu_status (clear first, then OR).
REQ-031 FIFO pointers SHALL wrap modulo QDEPTH; count width clog2(QDEPTH)+1.

Reset
REQ-032 On rst: FSM=IDLE, FIFO empty, frm=0, fflags=0, done_valid=0, done_illegal=0, done_tag=0, fpu_in_valid=0, busy=0, req_ready=1.
REQ-033 rst mid-operation SHALL abandon the in-flight op; a later fpu_out_valid in IDLE SHALL be ignored.

Verification
REQ-034 Single op: req_op=ADD, rm=0, tag=3, fpu_in_ready=1, fpu_out_valid 4 cycles after issue with status 5'b00001 -> fpu_in_valid cycle 2, done_valid tag 3, fflags=00001.
REQ-035 Dynamic rm: frm written 2, then req rm=7 -> fpu_rnd_mode=2; frm rewritten 4 while queued -> still 2.
REQ-036 Illegal: frm=5, req rm=7 tag 9 -> no fpu_in_valid, done_valid done_illegal=1 tag 9, fflags unchanged.
REQ-037 Backpressure/full: fpu_in_ready=0 for 10 cycles, 3 reqs offered -> req_ready low after 2 accepted, fpu_op stable, order preserved.
REQ-038 Flush in WAIT -> DRAIN; later fpu_out_valid status 10000 -> no done_valid, fflags unchanged, next queued op issues.
REQ-039 fflags_clr coincident with completion status 00100, prior fflags 00001 -> fflags=00100.

Source files
------------

// File: rtl/exu_fpu_seq_ctl.sv
// FPU sequencer: queues decoded FP ops, resolves rounding mode, issues one op at a time, tracks fflags.
// Latency: accept -> fpu_in_valid two cycles later; fpu_out_valid -> done_valid one cycle later.
// Backpressure: req_ready drops when the request FIFO is full; the issued op holds until fpu_in_ready.
module exu_fpu_seq_ctl #(
    parameter int QDEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [2:0] req_rm,
    input  logic [4:0] req_tag,
    input  logic       flush,
    output logic       fpu_in_valid,
    input  logic       fpu_in_ready,
    output logic [3:0] fpu_op,
    output logic [2:0] fpu_rnd_mode,
    input  logic       fpu_out_valid,
    input  logic [4:0] fpu_status,
    input  logic       frm_wr_en,
    input  logic [2:0] frm_wr_data,
    input  logic       fflags_clr,
    output logic [2:0] frm,
    output logic [4:0] fflags,
    output logic       done_valid,
    output logic [4:0] done_tag,
    output logic       done_illegal,
    output logic       busy
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    // Entry layout: {illegal, resolved rm, op, tag}
    typedef struct packed {
        logic       illegal;
        logic [2:0] rm;
        logic [3:0] op;
        logic [4:0] tag;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          mem_q [QDEPTH];
    entry_t          mem_d [QDEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      frm_q, frm_d;
    logic [4:0]      fflags_q, fflags_d;
    logic [4:0]      tag_q, tag_d;
    logic            done_valid_q, done_valid_d;
    logic [4:0]      done_tag_q, done_tag_d;
    logic            done_illegal_q, done_illegal_d;

    entry_t          head, entry_in;
    logic            not_full, not_empty, push, pop, illegal_pop, result_ok;

    // FIFO status, head entry and rounding-mode resolution at enqueue (uses frm before any same-cycle write)
    always_comb begin
        not_full          = (count_q < DEPTH_C);
        not_empty         = (count_q != '0);
        head              = mem_q[rd_ptr_q];
        entry_in.tag      = req_tag;
        entry_in.op       = req_op;
        entry_in.rm       = (req_rm == 3'd7) ? frm_q : req_rm;
        entry_in.illegal  = (entry_in.rm >= 3'd5);
        push              = req_valid && not_full && !flush;
        illegal_pop       = (state_q == IDLE) && not_empty && head.illegal;
        pop               = illegal_pop || ((state_q == ISSUE) && fpu_in_ready);
        result_ok         = (state_q == WAIT) && fpu_out_valid && !flush;
    end

    // FIFO storage, pointers and occupancy; flush empties the queue and drops any same-cycle request
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry_in;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // CSR state, issued-tag capture and registered completion pulse
    always_comb begin
        frm_d          = frm_wr_en ? frm_wr_data : frm_q;
        fflags_d       = fflags_clr ? 5'd0 : fflags_q;
        tag_d          = tag_q;
        done_valid_d   = 1'b0;
        done_illegal_d = 1'b0;
        done_tag_d     = done_tag_q;
        if ((state_q == ISSUE) && fpu_in_ready) begin
            tag_d = head.tag;
        end
        if (result_ok) begin
            fflags_d     = fflags_d | fpu_status;
            done_valid_d = 1'b1;
            done_tag_d   = tag_q;
        end else if (illegal_pop && !flush) begin
            done_valid_d   = 1'b1;
            done_illegal_d = 1'b1;
            done_tag_d     = head.tag;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush && not_empty && !head.illegal) state_d = ISSUE;
            end
            ISSUE: begin
                if (flush)             state_d = fpu_in_ready ? DRAIN : IDLE;
                else if (fpu_in_ready) state_d = WAIT;
            end
            WAIT: begin
                if (fpu_out_valid)     state_d = IDLE;
                else if (flush)        state_d = DRAIN;
            end
            DRAIN: begin
                if (fpu_out_valid)     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and status
    always_comb begin
        fpu_in_valid = (state_q == ISSUE);
        fpu_op       = head.op;
        fpu_rnd_mode = head.rm;
        req_ready    = not_full;
        busy         = not_empty || (state_q != IDLE);
        frm          = frm_q;
        fflags       = fflags_q;
        done_valid   = done_valid_q;
        done_tag     = done_tag_q;
        done_illegal = done_illegal_q;
    end

    // State register; FIFO payload is not reset since occupancy guards it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            frm_q          <= 3'd0;
            fflags_q       <= 5'd0;
            tag_q          <= 5'd0;
            done_valid_q   <= 1'b0;
            done_tag_q     <= 5'd0;
            done_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            frm_q          <= frm_d;
            fflags_q       <= fflags_d;
            tag_q          <= tag_d;
            done_valid_q   <= done_valid_d;
            done_tag_q     <= done_tag_d;
            done_illegal_q <= done_illegal_d;
        end
    end

endmodule
